axi_gen_sched: RTL and testbench
================================

AXI_GEN_SCHED -- requirements
Module: axi_gen_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of packet requesters.
REQ-002 SHALL have parameter LENGTH_WIDTH, default 9, meaning packet byte-length width.
REQ-003 SHALL have parameter GAP_WIDTH, default 8, meaning inter-packet idle-count width.
REQ-004 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_enable  input  1  permits new grants when high.
REQ-007 SHALL have port i_req  input  NUM_REQ  per-requester request level, held until acked.
REQ-008 SHALL have port i_req_len  input  NUM_REQ*LENGTH_WIDTH  per-requester byte length; slice k belongs to requester k.
REQ-009 SHALL have port i_gap  input  GAP_WIDTH  idle cycles inserted after each packet.
REQ-010 SHALL have port o_req_ack  output  NUM_REQ  one-hot, one-cycle acceptance pulse.
REQ-011 SHALL have port o_req_done  output  NUM_REQ  one-hot, one-cycle completion pulse.
REQ-012 SHALL have port o_req_err  output  NUM_REQ  one-hot, one-cycle zero-length rejection pulse.
REQ-013 SHALL have port o_gen_start  output  1  one-cycle start pulse to the data generator.
REQ-014 SHALL have port o_gen_length  output  LENGTH_WIDTH  byte length to the generator.
REQ-015 SHALL have port i_gen_valid  input  1  generator beat-transfer indication.
REQ-016 SHALL have port i_gen_last  input  1  generator last-beat indication.
REQ-017 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port o_grant_id  output  $clog2(NUM_REQ)  index of current/last granted requester.
REQ-019 SHALL have port o_pkt_cnt  output  16  count of completed packets, saturating at 0xFFFF.

Function
REQ-020 SHALL implement states IDLE, START, RUN, GAP.
REQ-021 SHALL, in IDLE with i_enable=1 and any i_req bit set, select one requester round-robin, starting at pointer, and register its index and length.
REQ-022 SHALL reset the round-robin pointer to 0 and set it to grant index+1 (mod NUM_REQ) on each grant.
REQ-023 SHALL, on a grant with non-zero length, enter START; in START, assert o_gen_start and o_req_ack[grant] for exactly one cycle, then enter RUN.
REQ-024 SHALL, on a grant with zero length, pulse o_req_err[grant] for one cycle, never assert o_gen_start, advance the pointer, and remain in IDLE.
REQ-025 SHALL hold o_gen_length at the registered length from START through RUN; it SHALL not change while RUN.
REQ-026 SHALL, in RUN, on a cycle with i_gen_valid & i_gen_last, pulse o_req_done[grant] the next cycle and increment o_pkt_cnt.
REQ-027 SHALL, after the last beat, enter GAP loaded with i_gap; if i_gap=0, go directly to IDLE.
REQ-028 SHALL count GAP down once per cycle and return to IDLE after exactly i_gap cycles.
REQ-029 SHALL give request-to-start latency of 2 cycles from i_req sampled high in IDLE.
REQ-030 SHALL ignore i_gen_valid and i_gen_last outside RUN.
REQ-031 SHALL block new grants on i_enable=0 without aborting a packet in START, RUN or GAP.
REQ-032 SHALL ignore requests dropped before ack; a requester whose i_req is low in the IDLE arbitration cycle is not granted.

Reset
REQ-033 SHALL, on rst, force state IDLE, pointer 0, o_grant_id 0, o_pkt_cnt 0, o_gen_length 0, and deassert all pulse outputs and o_busy, including mid-RUN.

Structure
REQ-034 SHALL take the state enumeration and the 16-bit counter width from shared package axi_gen_pkg.
REQ-035 SHALL place the round-robin selector in sub-module rr_arbiter (inputs req and pointer; outputs grant index and grant-valid).

Verification
REQ-036 SHALL cover a single request: req[0], len=20, gap=0 -> ack[0] 1 cycle after sample, start pulse, length=20, done[0] after last beat, pkt_cnt=1.
REQ-037 SHALL cover contention: req=4'b1111 all len=8 -> grant order 0,1,2,3,0 while held; one ack per grant.
REQ-038 SHALL cover zero length: req[2], len=0 -> err[2] pulse, no o_gen_start, state IDLE, pkt_cnt unchanged.
REQ-039 SHALL cover gap: gap=5 -> exactly 5 cycles between last beat and next IDLE grant cycle; o_busy high throughout.
REQ-040 SHALL cover mid-RUN reset: rst asserted mid-RUN -> all outputs at reset values next cycle; a later request is served normally.
REQ-041 SHALL cover enable drop: i_enable=0 during RUN -> current packet completes with done; no further ack until i_enable=1.

Source files
------------

// File: rtl/axi_gen_pkg.sv
// axi_gen_pkg: shared scheduler state encoding and counter width
package axi_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int CNT_WIDTH = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first asserted request at or after the pointer, wrapping around
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      pointer,
    output logic [IW-1:0]      grant,
    output logic               grant_valid
);

    logic [IW-1:0] cand;

    // scan offsets from farthest to nearest so the nearest active requester wins
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IW'((int'(pointer) + i) % NUM_REQ);
            if (req[cand]) begin
                grant       = cand;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_gen_sched.sv
// axi_gen_sched: round-robin packet scheduler driving a data generator with inter-packet gaps
module axi_gen_sched
    import axi_gen_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int LENGTH_WIDTH = 9,
    parameter int GAP_WIDTH    = 8,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_enable,
    input  logic [NUM_REQ-1:0]              i_req,
    input  logic [NUM_REQ*LENGTH_WIDTH-1:0] i_req_len,
    input  logic [GAP_WIDTH-1:0]            i_gap,
    output logic [NUM_REQ-1:0]              o_req_ack,
    output logic [NUM_REQ-1:0]              o_req_done,
    output logic [NUM_REQ-1:0]              o_req_err,
    output logic                            o_gen_start,
    output logic [LENGTH_WIDTH-1:0]         o_gen_length,
    input  logic                            i_gen_valid,
    input  logic                            i_gen_last,
    output logic                            o_busy,
    output logic [IW-1:0]                   o_grant_id,
    output logic [CNT_WIDTH-1:0]            o_pkt_cnt
);

    state_t                state, state_nxt;
    logic [IW-1:0]         ptr, arb_idx;
    logic                  arb_valid, grant, zero_len, last_beat;
    logic [GAP_WIDTH-1:0]  gap_cnt;
    logic [LENGTH_WIDTH-1:0] lens [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_len
        assign lens[k] = i_req_len[k*LENGTH_WIDTH +: LENGTH_WIDTH];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req         (i_req),
        .pointer     (ptr),
        .grant       (arb_idx),
        .grant_valid (arb_valid)
    );

    assign grant     = state == IDLE && i_enable && arb_valid;
    assign zero_len  = lens[arb_idx] == '0;
    assign last_beat = state == RUN && i_gen_valid && i_gen_last;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state: zero-length grants stay idle, a zero gap skips GAP entirely
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (grant && !zero_len) ? START : IDLE;
            START:   state_nxt = RUN;
            RUN:     state_nxt = last_beat ? ((i_gap == '0) ? IDLE : GAP) : RUN;
            GAP:     state_nxt = (gap_cnt == GAP_WIDTH'(1)) ? IDLE : GAP;
            default: state_nxt = IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        o_busy      = state != IDLE;
        o_gen_start = state == START;
        o_req_ack   = (state == START) ? NUM_REQ'(1) << o_grant_id : '0;
    end

    // grant capture, pointer, gap countdown, completion/error pulses and packet count
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            o_grant_id   <= '0;
            o_gen_length <= '0;
            gap_cnt      <= '0;
            o_req_done   <= '0;
            o_req_err    <= '0;
            o_pkt_cnt    <= '0;
        end else begin
            o_req_done <= last_beat ? NUM_REQ'(1) << o_grant_id : '0;
            o_req_err  <= (grant && zero_len) ? NUM_REQ'(1) << arb_idx : '0;
            if (grant) begin
                o_grant_id   <= arb_idx;
                o_gen_length <= lens[arb_idx];
                ptr          <= (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end
            if (last_beat)          gap_cnt <= i_gap;
            else if (state == GAP)  gap_cnt <= gap_cnt - 1'b1;
            if (last_beat && o_pkt_cnt != '1) o_pkt_cnt <= o_pkt_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_gen_sched.sv
// tb_axi_gen_sched: directed stimulus with a scoreboard of expected ack/err/done events
module tb_axi_gen_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_enable = 1'b0;
    logic [3:0]  i_req = '0;
    logic [35:0] i_req_len = '0;
    logic [7:0]  i_gap = '0;
    logic        i_gen_valid = 1'b0;
    logic        i_gen_last = 1'b0;
    logic [3:0]  o_req_ack, o_req_done, o_req_err;
    logic        o_gen_start, o_busy;
    logic [8:0]  o_gen_length;
    logic [1:0]  o_grant_id;
    logic [15:0] o_pkt_cnt;

    axi_gen_sched dut (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (i_enable),
        .i_req        (i_req),
        .i_req_len    (i_req_len),
        .i_gap        (i_gap),
        .o_req_ack    (o_req_ack),
        .o_req_done   (o_req_done),
        .o_req_err    (o_req_err),
        .o_gen_start  (o_gen_start),
        .o_gen_length (o_gen_length),
        .i_gen_valid  (i_gen_valid),
        .i_gen_last   (i_gen_last),
        .o_busy       (o_busy),
        .o_grant_id   (o_grant_id),
        .o_pkt_cnt    (o_pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        start;
        logic [3:0]  ack;
        logic [3:0]  err;
        logic [3:0]  done;
        logic [8:0]  len;
        logic [15:0] cnt;
    } ev_t;

    ev_t sb[$];
    ev_t mon_a, mon_e;
    int  checks = 0;
    int  errors = 0;
    int  exp_cnt = 0;
    int  lat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // kind 0 = ack+start, 1 = err, 2 = done
    task automatic push(input int kind, input int id, input int len, input int cnt);
        ev_t e;
        e = '0;
        e.cnt = 16'(cnt);
        if (kind == 0) begin
            e.start = 1'b1;
            e.ack   = 4'(1 << id);
            e.len   = 9'(len);
        end else if (kind == 1) e.err = 4'(1 << id);
        else e.done = 4'(1 << id);
        sb.push_back(e);
    endtask

    task automatic set_len(input int k, input int v);
        i_req_len[k*9 +: 9] = 9'(v);
    endtask

    task automatic wait_ack(input int id, output int n);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (o_req_ack != 0) break;
        end
        if (o_req_ack == 0) chk("ack_timeout", 64'(n), 64'(0));
        else chk("grant_id", 64'(o_grant_id), 64'(id));
    endtask

    task automatic beats(input int n, input int len);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            chk("gen_length_run", 64'(o_gen_length), 64'(len));
            chk("busy_run", 64'(o_busy), 64'(1));
            i_gen_valid = 1'b1;
            i_gen_last  = (i == n - 1);
            @(posedge clk); #1;
        end
        i_gen_valid = 1'b0;
        i_gen_last  = 1'b0;
    endtask

    task automatic serve(input int id, input int len, input int nb, input logic [3:0] req_after,
                         input logic en_after, output int n);
        push(0, id, len, exp_cnt);
        wait_ack(id, n);
        i_req    = req_after;
        i_enable = en_after;
        push(2, id, 0, exp_cnt + 1);
        exp_cnt++;
        beats(nb, len);
    endtask

    // monitor: every pulse the DUT presents must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && (o_gen_start || (o_req_ack | o_req_err | o_req_done) != 0)) begin
            mon_a = {o_gen_start, o_req_ack, o_req_err, o_req_done,
                     o_gen_start ? o_gen_length : 9'd0, o_pkt_cnt};
            if (sb.size() == 0) chk("event_unexpected", 64'(mon_a), 64'(0));
            else begin
                mon_e = sb.pop_front();
                chk("event", 64'(mon_a), 64'(mon_e));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_grant_id", 64'(o_grant_id), 64'(0));
        chk("rst_pkt_cnt", 64'(o_pkt_cnt), 64'(0));
        chk("rst_length", 64'(o_gen_length), 64'(0));
        chk("rst_pulses", 64'({o_gen_start, o_req_ack, o_req_err, o_req_done}), 64'(0));
        i_enable = 1'b1;

        // contention: all four held, grants 0,1,2,3,0
        for (int k = 0; k < 4; k++) set_len(k, 8);
        i_req = 4'b1111;
        for (int k = 0; k < 5; k++)
            serve(k % 4, 8, 2, (k == 4) ? 4'b0000 : 4'b1111, 1'b1, lat);

        // single request: ack on the second falling edge after driving req
        set_len(0, 20);
        @(posedge clk); #1;
        i_req = 4'b0001;
        serve(0, 20, 3, 4'b0000, 1'b1, lat);
        chk("ack_latency", 64'(lat), 64'(2));
        chk("pkt_cnt_single", 64'(o_pkt_cnt), 64'(6));

        // zero length on requester 2: error pulse only, stay idle
        set_len(2, 0);
        @(posedge clk); #1;
        i_req = 4'b0100;
        push(1, 2, 0, exp_cnt);
        @(posedge clk); #1;
        i_req = 4'b0000;
        repeat (3) begin
            chk("zero_busy", 64'(o_busy), 64'(0));
            @(posedge clk); #1;
        end
        chk("zero_grant_id", 64'(o_grant_id), 64'(2));
        chk("zero_pkt_cnt", 64'(o_pkt_cnt), 64'(exp_cnt));

        // gap of 5: busy for exactly 5 cycles after the last beat
        i_gap = 8'd5;
        set_len(1, 8);
        i_req = 4'b0010;
        serve(1, 8, 2, 4'b0000, 1'b1, lat);
        for (int k = 0; k < 5; k++) begin
            chk("gap_busy", 64'(o_busy), 64'(1));
            @(posedge clk); #1;
        end
        chk("gap_idle", 64'(o_busy), 64'(0));
        i_gap = 8'd0;

        // enable drop during RUN: packet finishes, pending req 0 waits
        set_len(3, 8);
        set_len(0, 8);
        i_req = 4'b1000;
        serve(3, 8, 2, 4'b0001, 1'b0, lat);
        for (int k = 0; k < 4; k++) begin
            chk("dis_busy", 64'(o_busy), 64'(0));
            i_gen_valid = (k == 1);
            i_gen_last  = (k == 1);
            @(posedge clk); #1;
        end
        i_gen_valid = 1'b0;
        i_gen_last  = 1'b0;
        chk("dis_pkt_cnt", 64'(o_pkt_cnt), 64'(exp_cnt));
        i_enable = 1'b1;
        serve(0, 8, 2, 4'b0000, 1'b1, lat);

        // reset mid-RUN, then a fresh request is served from pointer 0
        set_len(1, 8);
        i_req = 4'b0010;
        push(0, 1, 8, exp_cnt);
        wait_ack(1, lat);
        i_req = 4'b0000;
        @(posedge clk); #1;
        i_gen_valid = 1'b1;
        @(posedge clk); #1;
        i_gen_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_busy", 64'(o_busy), 64'(0));
        chk("mrst_grant_id", 64'(o_grant_id), 64'(0));
        chk("mrst_pkt_cnt", 64'(o_pkt_cnt), 64'(0));
        chk("mrst_length", 64'(o_gen_length), 64'(0));
        chk("mrst_pulses", 64'({o_gen_start, o_req_ack, o_req_err, o_req_done}), 64'(0));
        exp_cnt = 0;
        set_len(2, 12);
        i_req = 4'b0100;
        serve(2, 12, 4, 4'b0000, 1'b1, lat);
        chk("mrst_pkt_cnt_after", 64'(o_pkt_cnt), 64'(1));

        repeat (3) @(posedge clk);
        #1 chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
